// File: rtl/tomasulo_core_if.sv
// Host-side bus of tomasulo_core: issue port, instruction-memory load, CDB monitor, debug read.
interface tomasulo_core_if #(
    parameter int unsigned DATA_W = 16
);
    logic [3:0]        pc;
    logic              issue_en;
    logic              stall;
    logic              imem_we;
    logic [3:0]        imem_waddr;
    logic [15:0]       imem_wdata;
    logic              cdb_valid;
    logic [2:0]        cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic [3:0]        dbg_raddr;
    logic [DATA_W-1:0] dbg_rdata;
    logic              idle;

    modport master (
        output pc, issue_en, imem_we, imem_waddr, imem_wdata, dbg_raddr,
        input  stall, cdb_valid, cdb_tag, cdb_data, dbg_rdata, idle
    );

    modport slave (
        input  pc, issue_en, imem_we, imem_waddr, imem_wdata, dbg_raddr,
        output stall, cdb_valid, cdb_tag, cdb_data, dbg_rdata, idle
    );
endinterface

// File: rtl/tomasulo_core.sv
// Single-issue Tomasulo core: add/logic and multiply reservation stations sharing one CDB.
// Define TOMASULO_DIV_EN to execute opcode 6 as unsigned DIV on the multiply unit.
module tomasulo_core #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADD_RS  = 3,
    parameter int unsigned MUL_RS  = 2,
    parameter int unsigned MUL_LAT = 3
) (
    input logic            clk1,
    input logic            rst,
    tomasulo_core_if.slave bus
);
    localparam int unsigned NumRs = ADD_RS + MUL_RS;
    localparam int unsigned TagW  = 3;
    localparam int unsigned CntW  = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {ClsNone, ClsAdd, ClsMul} cls_e;

    function automatic cls_e op_class(input logic [3:0] op);
        cls_e cls;
        cls = ClsNone;
        if (op >= 4'd1 && op <= 4'd4) begin
            cls = ClsAdd;
        end else if (op == 4'd5) begin
            cls = ClsMul;
        end
`ifdef TOMASULO_DIV_EN
        else if (op == 4'd6) begin
            cls = ClsMul;
        end
`endif
        return cls;
    endfunction

    logic [15:0]       r_imem [16];
    logic [DATA_W-1:0] r_regs [16];
    logic [TagW-1:0]   r_qi   [16];

    logic [NumRs-1:0]  r_busy;
    logic [NumRs-1:0]  r_disp;
    logic [3:0]        r_op [NumRs];
    logic [DATA_W-1:0] r_vj [NumRs];
    logic [DATA_W-1:0] r_vk [NumRs];
    logic [TagW-1:0]   r_qj [NumRs];
    logic [TagW-1:0]   r_qk [NumRs];

    logic              r_add_busy;
    logic [TagW-1:0]   r_add_tag;
    logic [DATA_W-1:0] r_add_res;
    logic              r_mul_busy;
    logic [TagW-1:0]   r_mul_tag;
    logic [DATA_W-1:0] r_mul_res;
    logic [CntW-1:0]   r_mul_cnt;

    // CDB: the multiplier always wins; a losing adder simply holds its result.
    logic              w_mul_done, w_add_bcast, w_cdb_valid;
    logic [TagW-1:0]   w_cdb_tag;
    logic [DATA_W-1:0] w_cdb_data;

    always_comb begin
        w_mul_done  = r_mul_busy && (r_mul_cnt == '0);
        w_add_bcast = r_add_busy && !w_mul_done;
        w_cdb_valid = w_mul_done || w_add_bcast;
        w_cdb_tag   = '0;
        w_cdb_data  = '0;
        if (w_mul_done) begin
            w_cdb_tag  = r_mul_tag;
            w_cdb_data = r_mul_res;
        end else if (w_add_bcast) begin
            w_cdb_tag  = r_add_tag;
            w_cdb_data = r_add_res;
        end
    end

    logic [15:0]     w_instr;
    logic [3:0]      w_op, w_rd, w_rs1, w_rs2;
    cls_e            w_cls;
    logic            w_add_free, w_mul_free, w_alloc_ok, w_stall, w_issue;
    logic [TagW-1:0] w_add_idx, w_mul_idx, w_alloc_idx;

    assign w_instr = r_imem[bus.pc];
    assign w_op    = w_instr[15:12];
    assign w_rd    = w_instr[11:8];
    assign w_rs1   = w_instr[7:4];
    assign w_rs2   = w_instr[3:0];
    assign w_cls   = op_class(w_op);

    // Lowest free station per class; only registered busy bits count, so a station
    // freed by this cycle's broadcast is not handed out until the next cycle.
    always_comb begin
        w_add_free = 1'b0;
        w_add_idx  = '0;
        for (int i = int'(ADD_RS) - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_add_free = 1'b1;
                w_add_idx  = TagW'(i);
            end
        end
        w_mul_free = 1'b0;
        w_mul_idx  = '0;
        for (int i = int'(NumRs) - 1; i >= int'(ADD_RS); i--) begin
            if (!r_busy[i]) begin
                w_mul_free = 1'b1;
                w_mul_idx  = TagW'(i);
            end
        end
    end

    always_comb begin
        w_alloc_ok  = 1'b0;
        w_alloc_idx = w_add_idx;
        if (w_cls == ClsAdd) begin
            w_alloc_ok = w_add_free;
        end else if (w_cls == ClsMul) begin
            w_alloc_ok  = w_mul_free;
            w_alloc_idx = w_mul_idx;
        end
        w_stall = bus.issue_en && (w_cls != ClsNone) && !w_alloc_ok;
        w_issue = bus.issue_en && (w_cls != ClsNone) && w_alloc_ok;
    end

    // Operand capture with CDB bypass for a tag broadcast in the issue cycle.
    logic [TagW-1:0]   w_q1, w_q2, w_t1, w_t2;
    logic [DATA_W-1:0] w_v1, w_v2;

    always_comb begin
        w_q1 = r_qi[w_rs1];
        w_q2 = r_qi[w_rs2];
        w_v1 = '0;
        w_t1 = w_q1;
        if (w_q1 == '0) begin
            w_v1 = r_regs[w_rs1];
        end else if (w_cdb_valid && (w_cdb_tag == w_q1)) begin
            w_v1 = w_cdb_data;
            w_t1 = '0;
        end
        w_v2 = '0;
        w_t2 = w_q2;
        if (w_q2 == '0) begin
            w_v2 = r_regs[w_rs2];
        end else if (w_cdb_valid && (w_cdb_tag == w_q2)) begin
            w_v2 = w_cdb_data;
            w_t2 = '0;
        end
    end

    logic [NumRs-1:0]  w_rdy;
    logic              w_add_go, w_mul_go;
    logic [TagW-1:0]   w_add_sel, w_mul_sel;
    logic [DATA_W-1:0] w_aj, w_ak, w_mj, w_mk, w_alu_res, w_mul_val;

    always_comb begin
        for (int i = 0; i < int'(NumRs); i++) begin
            w_rdy[i] = r_busy[i] && !r_disp[i] && (r_qj[i] == '0) && (r_qk[i] == '0);
        end
        w_add_go  = 1'b0;
        w_add_sel = '0;
        for (int i = int'(ADD_RS) - 1; i >= 0; i--) begin
            if (w_rdy[i]) begin
                w_add_go  = 1'b1;
                w_add_sel = TagW'(i);
            end
        end
        w_mul_go  = 1'b0;
        w_mul_sel = TagW'(ADD_RS);
        for (int i = int'(NumRs) - 1; i >= int'(ADD_RS); i--) begin
            if (w_rdy[i]) begin
                w_mul_go  = 1'b1;
                w_mul_sel = TagW'(i);
            end
        end
        // A unit may take new work in the cycle its result wins the CDB.
        w_add_go = w_add_go && (!r_add_busy || w_add_bcast);
        w_mul_go = w_mul_go && (!r_mul_busy || w_mul_done);
    end

    assign w_aj = r_vj[w_add_sel];
    assign w_ak = r_vk[w_add_sel];
    assign w_mj = r_vj[w_mul_sel];
    assign w_mk = r_vk[w_mul_sel];

    always_comb begin
        w_alu_res = '0;
        case (r_op[w_add_sel])
            4'd1:    w_alu_res = w_aj + w_ak;
            4'd2:    w_alu_res = w_aj - w_ak;
            4'd3:    w_alu_res = w_aj & w_ak;
            4'd4:    w_alu_res = w_aj | w_ak;
            default: w_alu_res = '0;
        endcase
    end

    always_comb begin
        w_mul_val = w_mj * w_mk;
`ifdef TOMASULO_DIV_EN
        if (r_op[w_mul_sel] == 4'd6) begin
            w_mul_val = (w_mk == '0) ? '1 : w_mj / w_mk;
        end
`endif
    end

    always_ff @(posedge clk1) begin
        if (bus.imem_we) begin
            r_imem[bus.imem_waddr] <= bus.imem_wdata;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                r_regs[k] <= DATA_W'(k);
                r_qi[k]   <= '0;
            end
            r_busy     <= '0;
            r_disp     <= '0;
            r_add_busy <= 1'b0;
            r_add_tag  <= '0;
            r_add_res  <= '0;
            r_mul_busy <= 1'b0;
            r_mul_tag  <= '0;
            r_mul_res  <= '0;
            r_mul_cnt  <= '0;
        end else begin
            if (w_cdb_valid) begin
                r_busy[w_cdb_tag - 3'd1] <= 1'b0;
                r_disp[w_cdb_tag - 3'd1] <= 1'b0;
                for (int k = 0; k < 16; k++) begin
                    if (r_qi[k] == w_cdb_tag) begin
                        r_regs[k] <= w_cdb_data;
                        r_qi[k]   <= '0;
                    end
                end
                for (int i = 0; i < int'(NumRs); i++) begin
                    if (r_busy[i] && (r_qj[i] == w_cdb_tag)) begin
                        r_vj[i] <= w_cdb_data;
                        r_qj[i] <= '0;
                    end
                    if (r_busy[i] && (r_qk[i] == w_cdb_tag)) begin
                        r_vk[i] <= w_cdb_data;
                        r_qk[i] <= '0;
                    end
                end
            end

            if (w_add_go) begin
                r_disp[w_add_sel] <= 1'b1;
                r_add_busy        <= 1'b1;
                r_add_tag         <= w_add_sel + 3'd1;
                r_add_res         <= w_alu_res;
            end else if (w_add_bcast) begin
                r_add_busy <= 1'b0;
            end

            if (w_mul_go) begin
                r_disp[w_mul_sel] <= 1'b1;
                r_mul_busy        <= 1'b1;
                r_mul_tag         <= w_mul_sel + 3'd1;
                r_mul_res         <= w_mul_val;
                r_mul_cnt         <= CntW'(MUL_LAT - 1);
            end else if (w_mul_done) begin
                r_mul_busy <= 1'b0;
            end else if (r_mul_busy) begin
                r_mul_cnt <= r_mul_cnt - 1'b1;
            end

            // Issued after the CDB writeback so a same-cycle WAW leaves the new tag in Qi.
            if (w_issue) begin
                r_busy[w_alloc_idx] <= 1'b1;
                r_disp[w_alloc_idx] <= 1'b0;
                r_op[w_alloc_idx]   <= w_op;
                r_vj[w_alloc_idx]   <= w_v1;
                r_qj[w_alloc_idx]   <= w_t1;
                r_vk[w_alloc_idx]   <= w_v2;
                r_qk[w_alloc_idx]   <= w_t2;
                r_qi[w_rd]          <= w_alloc_idx + 3'd1;
            end
        end
    end

    assign bus.stall     = w_stall;
    assign bus.cdb_valid = w_cdb_valid;
    assign bus.cdb_tag   = w_cdb_tag;
    assign bus.cdb_data  = w_cdb_data;
    assign bus.dbg_rdata = r_regs[bus.dbg_raddr];
    assign bus.idle      = (r_busy == '0) && !r_add_busy && !r_mul_busy;

endmodule

// File: tb/tb_tomasulo_core.sv
// Bench for tomasulo_core: in-order architectural model plus CDB scoreboard, and
// hand-computed timing checks for the directed scenarios.
module tb_tomasulo_core;
    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    int   cyc  = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    tomasulo_core_if #(.DATA_W(16)) bus ();

    tomasulo_core #(
        .DATA_W (16),
        .ADD_RS (3),
        .MUL_RS (2),
        .MUL_LAT(3)
    ) dut (
        .clk1(clk1),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk1 = ~clk1;
    always @(posedge clk1) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // Architectural model: in-order register values and the value each live tag owes.
    logic [15:0] m_imem [16];
    logic [15:0] m_reg  [16];
    bit          m_busy [1:5];
    logic [15:0] m_exp  [1:5];
    int          bc_cyc [1:5];
    logic [15:0] bc_data[1:5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int m_class(input logic [3:0] op);
        if (op >= 4'd1 && op <= 4'd4) return 1;
        if (op == 4'd5) return 2;
`ifdef TOMASULO_DIV_EN
        if (op == 4'd6) return 2;
`endif
        return 0;
    endfunction

    function automatic logic [15:0] m_eval(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [31:0] p;
        p = a * b;
        case (op)
            4'd1: return a + b;
            4'd2: return a - b;
            4'd3: return a & b;
            4'd4: return a | b;
            4'd5: return p[15:0];
`ifdef TOMASULO_DIV_EN
            4'd6: return (b == 16'd0) ? 16'hFFFF : a / b;
`endif
            default: return 16'd0;
        endcase
    endfunction

    always @(negedge clk1) begin : cmp
        logic [15:0] w;
        int          cls, ta, t;
        bit          exp_stall, exp_idle, live;
        if (rst) begin
            for (int k = 0; k < 16; k++) m_reg[k] = 16'(k);
            for (int k = 1; k <= 5; k++) begin
                m_busy[k]  = 1'b0;
                bc_cyc[k]  = -1;
                bc_data[k] = 16'd0;
            end
        end else begin
            exp_idle = 1'b1;
            for (int k = 1; k <= 5; k++) if (m_busy[k]) exp_idle = 1'b0;
            chk("idle", bus.idle, exp_idle);
            w   = m_imem[bus.pc];
            cls = m_class(w[15:12]);
            ta  = 0;
            if (cls == 1) begin
                for (int k = 3; k >= 1; k--) if (!m_busy[k]) ta = k;
            end else if (cls == 2) begin
                for (int k = 5; k >= 4; k--) if (!m_busy[k]) ta = k;
            end
            exp_stall = bus.issue_en && (cls != 0) && (ta == 0);
            chk("stall", bus.stall, exp_stall);
            if (bus.cdb_valid) begin
                t    = int'(bus.cdb_tag);
                live = 1'b0;
                if (t >= 1 && t <= 5) live = m_busy[t];
                chk("cdb_tag_live", live, 1);
                if (live) begin
                    chk("cdb_data", bus.cdb_data, m_exp[t]);
                    bc_cyc[t]  = cyc;
                    bc_data[t] = bus.cdb_data;
                    m_busy[t]  = 1'b0;
                end
            end
            if (bus.issue_en && ta != 0) begin
                m_exp[ta]        = m_eval(w[15:12], m_reg[w[7:4]], m_reg[w[3:0]]);
                m_reg[w[11:8]]   = m_exp[ta];
                m_busy[ta]       = 1'b1;
            end
        end
    end

    function automatic logic [15:0] ins(input int op, input int rd, input int a, input int b);
        logic [3:0] f0, f1, f2, f3;
        f0 = 4'(op);
        f1 = 4'(rd);
        f2 = 4'(a);
        f3 = 4'(b);
        return {f0, f1, f2, f3};
    endfunction

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input int a, input logic [15:0] w);
        bus.imem_we    = 1'b1;
        bus.imem_waddr = 4'(a);
        bus.imem_wdata = w;
        m_imem[a]      = w;
        tick();
        bus.imem_we = 1'b0;
    endtask

    task automatic issue(input int a, output int c);
        bit acc;
        acc         = 1'b0;
        c           = -1;
        bus.pc      = 4'(a);
        bus.issue_en = 1'b1;
        for (int n = 0; n < 64 && !acc; n++) begin
            @(negedge clk1);
            if (!bus.stall) begin
                acc = 1'b1;
                c   = cyc;
            end
            tick();
        end
        bus.issue_en = 1'b0;
        chk("issue_accepted", acc, 1);
    endtask

    task automatic wait_idle();
        bit got;
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk1);
            if (bus.idle) got = 1'b1;
        end
        chk("idle_reached", got, 1);
        tick();
    endtask

    task automatic rd_reg(input int k, output logic [15:0] v);
        bus.dbg_raddr = 4'(k);
        #1;
        v = bus.dbg_rdata;
    endtask

    task automatic check_regs();
        logic [15:0] v;
        for (int k = 0; k < 16; k++) begin
            rd_reg(k, v);
            chk($sformatf("reg%0d", k), v, m_reg[k]);
        end
    endtask

    initial begin
        int c, c1, c2, c3, c4;
        logic [15:0] v;
        bus.pc = 4'd0;
        bus.issue_en = 1'b0;
        bus.imem_we = 1'b0;
        bus.imem_waddr = 4'd0;
        bus.imem_wdata = 16'd0;
        bus.dbg_raddr = 4'd0;
        for (int a = 0; a < 16; a++) load(a, 16'd0);

        // Reset state
        do_reset();
        bus.dbg_raddr = 4'd5;
        #1;
        chk("rst_r5", bus.dbg_rdata, 16'd5);
        chk("rst_stall", bus.stall, 0);
        chk("rst_cdb_valid", bus.cdb_valid, 0);
        chk("rst_cdb_tag", bus.cdb_tag, 0);
        chk("rst_idle", bus.idle, 1);
        tick();

        // Single ADD
        load(0, ins(1, 1, 2, 3));
        do_reset();
        issue(0, c);
        wait_idle();
        chk("add_bc_cyc", bc_cyc[1], c + 2);
        chk("add_bc_data", bc_data[1], 16'd5);
        rd_reg(1, v);
        chk("add_r1", v, 16'd5);
        chk("add_idle", bus.idle, 1);
        check_regs();

        // MUL then dependent ADD
        load(0, ins(5, 4, 2, 3));
        load(1, ins(1, 5, 4, 1));
        do_reset();
        issue(0, c);
        issue(1, c1);
        chk("raw_issue_cyc", c1, c + 1);
        wait_idle();
        chk("raw_mul_cyc", bc_cyc[4], c + 4);
        chk("raw_mul_data", bc_data[4], 16'd6);
        chk("raw_add_cyc", bc_cyc[1], c + 6);
        chk("raw_add_data", bc_data[1], 16'd7);
        rd_reg(4, v);
        chk("raw_r4", v, 16'd6);
        rd_reg(5, v);
        chk("raw_r5", v, 16'd7);
        check_regs();

        // WAW: later ADD wins R6; Qi[6] must clear
        load(0, ins(5, 6, 2, 3));
        load(1, ins(1, 6, 1, 1));
        load(2, ins(1, 7, 6, 0));
        do_reset();
        issue(0, c);
        issue(1, c1);
        wait_idle();
        chk("waw_add_cyc", bc_cyc[1], c + 3);
        chk("waw_add_data", bc_data[1], 16'd2);
        chk("waw_mul_cyc", bc_cyc[4], c + 4);
        chk("waw_mul_data", bc_data[4], 16'd6);
        rd_reg(6, v);
        chk("waw_r6", v, 16'd2);
        issue(2, c2);
        wait_idle();
        chk("waw_qi_clear_cyc", bc_cyc[1], c2 + 2);
        chk("waw_r7_data", bc_data[1], 16'd2);
        check_regs();

        // Structural stall on the add stations
        load(0, ins(5, 4, 2, 3));
        for (int i = 0; i < 4; i++) load(1 + i, ins(1, 8 + i, 4, 1));
        do_reset();
        issue(0, c);
        issue(1, c1);
        issue(2, c2);
        issue(3, c3);
        issue(4, c4);
        chk("struct_c3", c3, c + 3);
        chk("struct_c4", c4, c + 7);
        wait_idle();
        rd_reg(11, v);
        chk("struct_r11", v, 16'd7);
        check_regs();

        // CDB conflict: MUL wins, ADD follows
        load(0, ins(5, 4, 2, 3));
        load(1, ins(1, 5, 1, 2));
        do_reset();
        issue(0, c);
        tick();
        issue(1, c1);
        chk("conf_issue_cyc", c1, c + 2);
        wait_idle();
        chk("conf_mul_cyc", bc_cyc[4], c + 4);
        chk("conf_add_cyc", bc_cyc[1], c + 5);
        chk("conf_add_data", bc_data[1], 16'd3);
        rd_reg(4, v);
        chk("conf_r4", v, 16'd6);
        rd_reg(5, v);
        chk("conf_r5", v, 16'd3);
        check_regs();

        // Mixed ops, wrap-around, NOP encodings, R0 as destination
        load(0, ins(2, 12, 1, 2));
        load(1, ins(3, 13, 12, 7));
        load(2, ins(4, 0, 13, 8));
        load(3, ins(5, 14, 12, 12));
        load(4, ins(0, 5, 5, 5));
        load(5, ins(6, 3, 9, 0));
        load(6, ins(15, 1, 1, 1));
        load(7, ins(1, 15, 0, 14));
        load(8, ins(5, 3, 15, 0));
        load(9, ins(1, 2, 3, 3));
        do_reset();
        for (int i = 0; i < 10; i++) issue(i, c);
        wait_idle();
        rd_reg(12, v);
        chk("mix_r12_wrap", v, 16'hFFFF);
        rd_reg(0, v);
        chk("mix_r0", v, 16'd15);
        rd_reg(15, v);
        chk("mix_r15", v, 16'd16);
        rd_reg(2, v);
        chk("mix_r2", v, 16'd480);
        check_regs();

        // Reset mid-operation discards in-flight MUL
        load(0, ins(5, 7, 2, 3));
        do_reset();
        issue(0, c);
        do_reset();
        wait_idle();
        repeat (6) tick();
        rd_reg(7, v);
        chk("midrst_r7", v, 16'd7);
        chk("midrst_idle", bus.idle, 1);
        check_regs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
